iadc_conv_ctrl: RTL and testbench



---
 rtl/iadc_pkg.sv | 18 +
 rtl/iadc_spi_tx.sv | 52 +++++
 rtl/iadc_conv_ctrl.sv | 119 +++++++++++
 tb/tb_iadc_conv_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/iadc_pkg.sv
// iadc_pkg -- shared types and constants for the incremental ADC controller.
//   state_e   : conversion FSM state encoding
//   acc_width : integrator width needed so acc2 cannot overflow for a given OSR
package iadc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RST,
    ST_CONV,
    ST_LATCH
  } state_e;

  // acc2 peaks at OSR*(OSR+1)/2 when the bitstream is all ones.
  function automatic int acc_width(input int osr);
    return $clog2(osr * (osr + 1) / 2 + 1);
  endfunction

endpackage

// File: rtl/iadc_spi_tx.sv
// iadc_spi_tx -- serial readout of the latched conversion result.
// sclk and cs_n come from another clock domain; both pass through 2-flop
// synchronisers and edges are detected on the synchronised copies.
// Ports:
//   clk, rst_n       system clock, async active-low reset
//   sclk, cs_n       asynchronous serial clock / select (active low)
//   data_in          parallel word loaded when select falls
//   serial_data_out  MSB-first serial bit, 0 while deselected
module iadc_spi_tx #(
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sclk,
  input  logic             cs_n,
  input  logic [OUT_W-1:0] data_in,
  output logic             serial_data_out
);

  logic [1:0]       sclk_sync, cs_sync;
  logic             sclk_d, cs_d;
  logic [OUT_W-1:0] sreg;
  logic             sclk_fall;

  assign sclk_fall = sclk_d & ~sclk_sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= 2'b00;
      cs_sync   <= 2'b11;
      sclk_d    <= 1'b0;
      cs_d      <= 1'b1;
      sreg      <= '0;
    end else begin
      sclk_sync <= {sclk_sync[0], sclk};
      cs_sync   <= {cs_sync[0], cs_n};
      sclk_d    <= sclk_sync[1];
      cs_d      <= cs_sync[1];
      // A snapshot is taken only on select falling, so a new result latched
      // mid-readout never corrupts the word being shifted out.
      if (cs_sync[1])
        sreg <= '0;
      else if (cs_d)
        sreg <= data_in;
      else if (sclk_fall)
        sreg <= {sreg[OUT_W-2:0], 1'b0};   // zero fill: output 0 after OUT_W bits
    end
  end

  assign serial_data_out = sreg[OUT_W-1] & ~cs_sync[1];

endmodule

// File: rtl/iadc_conv_ctrl.sv
// iadc_conv_ctrl -- incremental ADC conversion controller with a
// second-order cascade-of-integrators decimator.
// Each conversion: one RST cycle (integrator reset), OSR CONV cycles
// accumulating the modulator bitstream, one LATCH cycle publishing the top
// OUT_W bits of acc2.
// Ports:
//   clk, rst_n       system clock, async active-low reset
//   start            single conversion request (sampled in IDLE)
//   cont             continuous back-to-back conversions while high
//   data_in          modulator bitstream
//   sclk, cs_n       serial readout clock / select (asynchronous)
//   data_out         last conversion result
//   new_data         one-cycle pulse when data_out updates
//   serial_data_out  serial result, MSB first
//   int_rst          analog integrator reset
//   busy             high whenever not IDLE
// Build option: define IADC_SPI_EN to include the serial readout; otherwise
// sclk/cs_n are ignored and serial_data_out is 0.
module iadc_conv_ctrl
  import iadc_pkg::*;
#(
  parameter int OSR   = 256,
  parameter int OUT_W = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             cont,
  input  logic             data_in,
  input  logic             sclk,
  input  logic             cs_n,
  output logic [OUT_W-1:0] data_out,
  output logic             new_data,
  output logic             serial_data_out,
  output logic             int_rst,
  output logic             busy
);

  localparam int ACC_W = acc_width(OSR);
  localparam int CNT_W = $clog2(OSR);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);

  state_e           state;
  logic [ACC_W-1:0] acc1, acc2, din_ext;
  logic [CNT_W-1:0] cnt;

  assign din_ext = {{(ACC_W-1){1'b0}}, data_in};

  // Outputs are registered alongside the state so they track the state that
  // is being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      acc1     <= '0;
      acc2     <= '0;
      cnt      <= '0;
      data_out <= '0;
      new_data <= 1'b0;
      int_rst  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      new_data <= 1'b0;
      int_rst  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start | cont) begin
            state   <= ST_RST;
            int_rst <= 1'b1;
            busy    <= 1'b1;
          end
        end
        ST_RST: begin
          acc1  <= '0;
          acc2  <= '0;
          cnt   <= '0;
          state <= ST_CONV;
        end
        ST_CONV: begin
          acc1 <= acc1 + din_ext;
          acc2 <= acc2 + acc1 + din_ext;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) state <= ST_LATCH;
        end
        ST_LATCH: begin
          data_out <= acc2[ACC_W-1 -: OUT_W];
          new_data <= 1'b1;
          // start/cont are only re-examined here; mid-conversion changes wait.
          if (cont) begin
            state   <= ST_RST;
            int_rst <= 1'b1;
          end else begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef IADC_SPI_EN
  iadc_spi_tx #(.OUT_W(OUT_W)) u_spi (
    .clk             (clk),
    .rst_n           (rst_n),
    .sclk            (sclk),
    .cs_n            (cs_n),
    .data_in         (data_out),
    .serial_data_out (serial_data_out)
  );
`else
  logic unused_spi;
  assign unused_spi      = sclk ^ cs_n;
  assign serial_data_out = 1'b0;
`endif

endmodule

// File: tb/tb_iadc_conv_ctrl.sv
module tb_iadc_conv_ctrl;

  localparam int OSR_A = 256, OW_A = 12;
  localparam int OSR_B = 4,   OW_B = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic sclk = 1'b0, cs_n = 1'b1;

  logic start_a = 0, cont_a = 0, din_a = 0;
  logic [OW_A-1:0] dout_a;
  logic nd_a, sdo_a, ir_a, busy_a;

  logic start_b = 0, cont_b = 0, din_b = 0;
  logic [OW_B-1:0] dout_b;
  logic nd_b, sdo_b, ir_b, busy_b;

  int total = 0, bad = 0;
  bit pat [1024];

  always #5 clk = ~clk;

  iadc_conv_ctrl #(.OSR(OSR_A), .OUT_W(OW_A)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .cont(cont_a), .data_in(din_a),
    .sclk(sclk), .cs_n(cs_n), .data_out(dout_a), .new_data(nd_a),
    .serial_data_out(sdo_a), .int_rst(ir_a), .busy(busy_a));

  iadc_conv_ctrl #(.OSR(OSR_B), .OUT_W(OW_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .cont(cont_b), .data_in(din_b),
    .sclk(sclk), .cs_n(cs_n), .data_out(dout_b), .new_data(nd_b),
    .serial_data_out(sdo_b), .int_rst(ir_b), .busy(busy_b));

  typedef struct {
    bit          b;
    int          kind;
    logic [31:0] exp;
    string       nm;
  } vec_t;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // 0 zeros, 1 ones, 2 alternating (1 first), 3 first bit only, 4 last bit only, 5 random
  task automatic fill(input int kind, input int osr);
    for (int j = 0; j < osr; j++)
      case (kind)
        0: pat[j] = 1'b0;
        1: pat[j] = 1'b1;
        2: pat[j] = (j % 2 == 0);
        3: pat[j] = (j == 0);
        4: pat[j] = (j == osr - 1);
        default: pat[j] = 1'($urandom_range(0, 1));
      endcase
  endtask

  // A bit arriving on sample j (0-based) reaches acc2 once directly and once
  // per remaining sample through acc1: weight osr-j.
  function automatic logic [31:0] model(input int osr, input int ow);
    longint acc = 0;
    int accw;
    accw = $clog2(osr * (osr + 1) / 2 + 1);
    for (int j = 0; j < osr; j++) if (pat[j]) acc += longint'(osr - j);
    return 32'(acc >> (accw - ow));
  endfunction

  function automatic logic [31:0] rd_dout(input bit b);
    return b ? 32'(dout_b) : 32'(dout_a);
  endfunction

  task automatic set_in(input bit b, input logic st, input logic d);
    if (b) begin start_b = st; din_b = d; end
    else   begin start_a = st; din_a = d; end
  endtask

  // Single conversion with the bitstream in pat[]; start seen at edge k,
  // samples at edges k+2..k+OSR+1, result after edge k+OSR+2.
  task automatic conv(input bit b, input logic [31:0] exp, input string nm, input bit poke_start);
    int osr;
    osr = b ? OSR_B : OSR_A;
    set_in(b, 1'b1, 1'b0);
    tick();
    set_in(b, 1'b0, 1'b0);
    chk({nm, "_int_rst_on"}, b ? ir_b : ir_a, 1);
    chk({nm, "_busy"},       b ? busy_b : busy_a, 1);
    tick();
    chk({nm, "_int_rst_off"}, b ? ir_b : ir_a, 0);
    for (int i = 0; i < osr; i++) begin
      // start toggling mid-conversion must be ignored
      set_in(b, (poke_start && i < osr - 1) ? 1'($urandom_range(0, 1)) : 1'b0, pat[i]);
      tick();
    end
    set_in(b, 1'b0, 1'b0);
    chk({nm, "_nd_early"}, b ? nd_b : nd_a, 0);
    tick();
    chk({nm, "_nd"},     b ? nd_b : nd_a, 1);
    chk({nm, "_dout"},   rd_dout(b), exp);
    chk({nm, "_idle"},   b ? busy_b : busy_a, 0);
    tick();
    chk({nm, "_nd_one"}, b ? nd_b : nd_a, 0);
    chk({nm, "_hold"},   rd_dout(b), exp);
  endtask

  initial begin
    vec_t tbl[10];
    int nd_at[$], ir_at[$];
    logic [11:0] sh;

    tbl[0] = '{0, 1, 32'h808, "a_ones"};
    tbl[1] = '{0, 0, 32'h000, "a_zeros"};
    tbl[2] = '{0, 2, 32'h408, "a_alt"};
    tbl[3] = '{0, 3, 32'h010, "a_first"};
    tbl[4] = '{0, 4, 32'h000, "a_last"};
    tbl[5] = '{1, 1, 32'hA,   "b_ones"};
    tbl[6] = '{1, 0, 32'h0,   "b_zeros"};
    tbl[7] = '{1, 2, 32'h6,   "b_alt"};
    tbl[8] = '{1, 3, 32'h4,   "b_first"};
    tbl[9] = '{1, 4, 32'h1,   "b_last"};

    // reset state
    rst_n = 1'b0;
    ticks(3);
    chk("rst_dout_a", dout_a, 0);
    chk("rst_nd_a",   nd_a,   0);
    chk("rst_ir_a",   ir_a,   0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_sdo_a",  sdo_a,  0);
    chk("rst_dout_b", dout_b, 0);
    chk("rst_busy_b", busy_b, 0);
    rst_n = 1'b1;
    ticks(2);

    for (int t = 0; t < 10; t++) begin
      fill(tbl[t].kind, tbl[t].b ? OSR_B : OSR_A);
      conv(tbl[t].b, tbl[t].exp, tbl[t].nm, 1'b0);
      tick();
    end

    // randomized bitstreams against the weighted-sum model
    for (int r = 0; r < 8; r++) begin
      bit b;
      b = (r >= 2);
      fill(5, b ? OSR_B : OSR_A);
      conv(b, model(b ? OSR_B : OSR_A, b ? OW_B : OW_A), b ? "rnd_b" : "rnd_a", 1'b1);
      tick();
    end

    // continuous mode: pulses every OSR+2, cont dropped mid 4th conversion
    din_b = 1'b1;
    cont_b = 1'b1;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (nd_b) begin
        nd_at.push_back(c);
        chk("cont_dout", dout_b, 32'hA);
      end
      if (ir_b) ir_at.push_back(c);
      if (c == 19) cont_b = 1'b0;
      if (c >= 25) chk("cont_busy_end", busy_b, 0);
    end
    din_b = 1'b0;
    chk("cont_nd_count", nd_at.size(), 4);
    chk("cont_ir_count", ir_at.size(), 4);
    foreach (nd_at[k]) chk("cont_nd_pos", nd_at[k], (OSR_B + 2) * (k + 1));
    foreach (ir_at[k]) chk("cont_ir_pos", ir_at[k], (OSR_B + 2) * k);

    // reset at CONV sample 100 aborts without a pulse
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    tick();
    din_a = 1'b1;
    ticks(100);
    rst_n = 1'b0;
    #1;
    chk("abort_dout", dout_a, 0);
    chk("abort_nd",   nd_a,   0);
    chk("abort_ir",   ir_a,   0);
    chk("abort_busy", busy_a, 0);
    chk("abort_sdo",  sdo_a,  0);
    ticks(3);
    chk("abort_nd_hold", nd_a, 0);
    rst_n = 1'b1;
    din_a = 1'b0;
    tick();
    chk("abort_no_nd", nd_a, 0);
    fill(1, OSR_A);
    conv(1'b0, 32'h808, "post_abort", 1'b0);
    ticks(2);

`ifdef IADC_SPI_EN
    sh = 12'h808;
    cs_n = 1'b0;
    ticks(8);
    chk("spi_bit0", sdo_a, sh[11]);
    for (int p = 0; p < 12; p++) begin
      sclk = 1'b1;
      ticks(4);
      sclk = 1'b0;
      ticks(4);
      sh = sh << 1;
      chk("spi_bit", sdo_a, sh[11]);
    end
    cs_n = 1'b1;
    ticks(6);
    chk("spi_idle", sdo_a, 0);
`else
    sh = 12'h0;
    cs_n = 1'b0;
    ticks(8);
    for (int p = 0; p < 12; p++) begin
      sclk = 1'b1;
      ticks(4);
      sclk = 1'b0;
      ticks(4);
      chk("nospi_sdo_a", sdo_a, 32'(sh[11]));
      chk("nospi_sdo_b", sdo_b, 32'(sh[11]));
    end
    cs_n = 1'b1;
    ticks(2);
`endif
    chk("final_dout", dout_a, 32'h808);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
